// File: rtl/timer_irq_8.sv
// 16-bit interval timer with prescaler and active-low IRQ for the 0x20xx I/O page.
// Optional build macro TIMER_RDCLR_EN: a STATUS read also clears TF.
module timer_irq_8 #(
   parameter logic [7:0] BASE_ADDR      = 8'h30,
   parameter int         PRESCALE_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sel,
   input  logic [7:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       we,
   output logic       irq_
);

   localparam int PW = PRESCALE_WIDTH;

   logic [15:0]   r_reload;
   logic [15:0]   r_count;
   logic [PW-1:0] r_prescale;
   logic [PW-1:0] r_pcnt;
   logic          r_en;
   logic          r_ie;
   logic          r_oneshot;
   logic          r_tf;
   logic          r_irq_n;
   logic [7:0]    r_cnt_hi_latch;

   logic       w_hit;
   logic       w_wr;
   logic       w_rd;
   logic [2:0] w_off;
   logic       w_load;
   logic       w_tick;
   logic       w_wrap;
   logic       w_w1c;
   logic       w_rdclr;
   logic       w_tf_clr;

   // BASE_ADDR is 8-aligned, so only the upper five address bits decode the block.
   assign w_hit  = sel && (addr[7:3] == BASE_ADDR[7:3]);
   assign w_off  = addr[2:0];
   assign w_wr   = w_hit && we;
   assign w_rd   = w_hit && !we;
   assign w_load = w_wr && (w_off == 3'd5) && din[3];
   assign w_tick = r_en && (r_pcnt == '0);
   assign w_wrap = w_tick && (r_count == 16'h0000) && !w_load;
   assign w_w1c  = w_wr && (w_off == 3'd6) && din[0];

`ifdef TIMER_RDCLR_EN
   assign w_rdclr = w_rd && (w_off == 3'd6);
`else
   assign w_rdclr = 1'b0;
`endif

   assign w_tf_clr = w_w1c || w_rdclr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_reload       <= 16'hFFFF;
         r_count        <= 16'hFFFF;
         r_prescale     <= '0;
         r_pcnt         <= '0;
         r_en           <= 1'b0;
         r_ie           <= 1'b0;
         r_oneshot      <= 1'b0;
         r_tf           <= 1'b0;
         r_irq_n        <= 1'b1;
         r_cnt_hi_latch <= 8'h00;
      end else begin
         if (w_wr && (w_off == 3'd0)) r_reload[7:0]  <= din;
         if (w_wr && (w_off == 3'd1)) r_reload[15:8] <= din;
         if (w_wr && (w_off == 3'd4)) r_prescale     <= PW'(din);

         if (w_load || !r_en || (r_pcnt == '0))
            r_pcnt <= r_prescale;
         else
            r_pcnt <= r_pcnt - PW'(1);

         // LOAD takes priority over a tick landing on the same edge.
         if (w_load)
            r_count <= r_reload;
         else if (w_tick) begin
            if (r_count == 16'h0000)
               r_count <= r_reload;
            else
               r_count <= r_count - 16'd1;
         end

         if (w_wr && (w_off == 3'd5)) begin
            r_en      <= din[0];
            r_ie      <= din[1];
            r_oneshot <= din[2];
         end else if (w_wrap && r_oneshot) begin
            r_en <= 1'b0;
         end

         r_tf <= w_wrap || (r_tf && !w_tf_clr);

         // Reading COUNT_LO snapshots the high byte so a LO/HI pair is coherent.
         if (w_rd && (w_off == 3'd2)) r_cnt_hi_latch <= r_count[15:8];

         r_irq_n <= ~(r_tf & r_ie);
      end
   end

   always_comb begin
      dout = 8'h00;
      if (w_hit) begin
         case (w_off)
            3'd0:    dout = r_reload[7:0];
            3'd1:    dout = r_reload[15:8];
            3'd2:    dout = r_count[7:0];
            3'd3:    dout = r_cnt_hi_latch;
            3'd4:    dout = 8'(r_prescale);
            3'd5:    dout = {5'b00000, r_oneshot, r_ie, r_en};
            3'd6:    dout = {7'b0000000, r_tf};
            default: dout = 8'h00;
         endcase
      end
   end

   assign irq_ = r_irq_n;

endmodule

// File: tb/tb_timer_irq_8.sv
// Directed bench for timer_irq_8: probes push expected dout/irq_ into queues, a monitor checks mid-cycle.
module tb_timer_irq_8;

   localparam logic [7:0] BASE = 8'h30;

   logic       clk;
   logic       reset;
   logic       sel;
   logic [7:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       we;
   logic       irq_;

   logic [7:0] exp_q[$];
   logic       exp_irq_q[$];
   string      name_q[$];
   logic       mon_on;
   int         checks;
   int         errors;

   timer_irq_8 #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(8)) dut (
      .clk  (clk),
      .reset(reset),
      .sel  (sel),
      .addr (addr),
      .din  (din),
      .dout (dout),
      .we   (we),
      .irq_ (irq_)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: each consumes one clock and leaves the bench 1 ns after a posedge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] off, input logic [7:0] d);
      sel  = 1'b1;
      we   = 1'b1;
      addr = BASE + {5'b00000, off};
      din  = d;
      @(posedge clk);
      #1;
      sel = 1'b0;
      we  = 1'b0;
   endtask

   task automatic probe_a(input logic s, input logic [7:0] a, input logic [7:0] ed,
                          input logic ei, input string nm);
      sel  = s;
      we   = 1'b0;
      addr = a;
      exp_q.push_back(ed);
      exp_irq_q.push_back(ei);
      name_q.push_back(nm);
      mon_on = 1'b1;
      @(posedge clk);
      #1;
      mon_on = 1'b0;
      sel    = 1'b0;
   endtask

   task automatic probe(input logic [2:0] off, input logic [7:0] ed, input logic ei,
                        input string nm);
      probe_a(1'b1, BASE + {5'b00000, off}, ed, ei, nm);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [7:0] ed;
      logic       ei;
      string      nm;
      if (mon_on) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow got dout=%02h irq_=%0b want queued entry", dout, irq_);
         end else begin
            ed = exp_q.pop_front();
            ei = exp_irq_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (dout !== ed) begin
               errors++;
               $display("FAIL %s dout got %02h want %02h", nm, dout, ed);
            end
            checks++;
            if (irq_ !== ei) begin
               errors++;
               $display("FAIL %s irq_ got %0b want %0b", nm, irq_, ei);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      mon_on = 1'b0;
      reset  = 1'b1;
      sel    = 1'b0;
      we     = 1'b0;
      addr   = 8'h00;
      din    = 8'h00;
      idle(3);
      reset = 1'b0;

      // Reset values; COUNT_HI read before COUNT_LO so the latch is still clear
      probe(3'd0, 8'hFF, 1'b1, "rst_reload_lo");
      probe(3'd1, 8'hFF, 1'b1, "rst_reload_hi");
      probe(3'd3, 8'h00, 1'b1, "rst_count_hi_latch");
      probe(3'd2, 8'hFF, 1'b1, "rst_count_lo");
      probe(3'd4, 8'h00, 1'b1, "rst_prescale");
      probe(3'd5, 8'h00, 1'b1, "rst_ctrl");
      probe(3'd6, 8'h00, 1'b1, "rst_status");
      probe(3'd7, 8'h00, 1'b1, "rst_reserved");
      probe(3'd3, 8'hFF, 1'b1, "latch_after_lo_read");
      probe_a(1'b0, BASE, 8'h00, 1'b1, "unselected_read");
      probe_a(1'b1, BASE + 8'h08, 8'h00, 1'b1, "out_of_range_read");
      wr(3'd7, 8'hFF);
      probe(3'd7, 8'h00, 1'b1, "reserved_write_ignored");

      // Periodic: reload 3, prescale 0, EN|IE|LOAD
      wr(3'd0, 8'h03);
      wr(3'd1, 8'h00);
      wr(3'd4, 8'h00);
      wr(3'd5, 8'h0B);
      probe(3'd2, 8'h03, 1'b1, "per_c0");
      probe(3'd2, 8'h02, 1'b1, "per_c1");
      probe(3'd2, 8'h01, 1'b1, "per_c2");
      probe(3'd6, 8'h00, 1'b1, "per_tf_not_yet");
      probe(3'd2, 8'h03, 1'b1, "per_wrap_irq_lag");
      probe(3'd2, 8'h02, 1'b0, "per_irq_fell");
      probe(3'd5, 8'h03, 1'b0, "per_ctrl_load_reads0");
      probe(3'd2, 8'h00, 1'b0, "per_c7");
      probe(3'd2, 8'h03, 1'b0, "per_second_wrap");

      // W1C colliding with a wrap: set wins
      idle(2);
      wr(3'd6, 8'h01);
      probe(3'd2, 8'h03, 1'b0, "w1c_collide_c12");
      probe(3'd2, 8'h02, 1'b0, "w1c_collide_irq_held");
      // W1C on a quiet cycle
      wr(3'd6, 8'h01);
      probe(3'd6, 8'h00, 1'b0, "w1c_tf_cleared");
      probe(3'd2, 8'h03, 1'b1, "w1c_irq_released");
      wr(3'd5, 8'h00);
      wr(3'd6, 8'h01);

      // One-shot: prescale 2, reload 1, EN|ONESHOT|LOAD
      wr(3'd4, 8'h02);
      wr(3'd0, 8'h01);
      wr(3'd1, 8'h00);
      wr(3'd5, 8'h0D);
      probe(3'd2, 8'h01, 1'b1, "os_c0");
      probe(3'd2, 8'h01, 1'b1, "os_c1");
      probe(3'd2, 8'h01, 1'b1, "os_c2");
      probe(3'd2, 8'h00, 1'b1, "os_c3");
      probe(3'd2, 8'h00, 1'b1, "os_c4");
      probe(3'd6, 8'h00, 1'b1, "os_tf_before_6");
      probe(3'd5, 8'h04, 1'b1, "os_en_cleared");
      probe(3'd6, 8'h01, 1'b1, "os_tf_set");
`ifdef TIMER_RDCLR_EN
      probe(3'd6, 8'h00, 1'b1, "rdclr_tf_cleared");
`else
      probe(3'd6, 8'h01, 1'b1, "no_rdclr_tf_persists");
`endif
      probe(3'd2, 8'h01, 1'b1, "os_count_holds");

      // Atomic 16-bit read across a borrow from 0x0100
      wr(3'd4, 8'h00);
      wr(3'd0, 8'h00);
      wr(3'd1, 8'h01);
      wr(3'd5, 8'h09);
      probe(3'd2, 8'h00, 1'b1, "atomic_lo");
      probe(3'd3, 8'h01, 1'b1, "atomic_hi");
      probe(3'd2, 8'hFE, 1'b1, "atomic_running");

      // Asynchronous reset mid-period with IRQ asserted
      wr(3'd5, 8'h00);
      wr(3'd6, 8'h01);
      wr(3'd0, 8'h02);
      wr(3'd1, 8'h00);
      wr(3'd5, 8'h0B);
      idle(3);
      probe(3'd2, 8'h02, 1'b1, "pre_rst_wrap");
      probe(3'd2, 8'h01, 1'b0, "pre_rst_irq_low");
      #1;
      reset = 1'b1;
      probe(3'd0, 8'hFF, 1'b1, "arst_reload_lo");
      probe(3'd1, 8'hFF, 1'b1, "arst_reload_hi");
      probe(3'd2, 8'hFF, 1'b1, "arst_count_lo");
      probe(3'd3, 8'h00, 1'b1, "arst_latch");
      probe(3'd4, 8'h00, 1'b1, "arst_prescale");
      probe(3'd5, 8'h00, 1'b1, "arst_ctrl");
      probe(3'd6, 8'h00, 1'b1, "arst_status");
      probe(3'd7, 8'h00, 1'b1, "arst_reserved");
      reset = 1'b0;
      probe(3'd2, 8'hFF, 1'b1, "post_rst_idle");
      idle(1);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
